fir_ram_seq_ctrl: RTL and testbench
===================================

Name: fir_ram_seq_ctrl

Overview:
Control sequencer directly upstream of ReConf_FirFilter. It generates every control input that filter needs: iCoeffUpdateFlag, iCsnRam, iWrnRam, iAddrRam, iWtDtRam, iEnMul, iEnAddAcc and iFirIn.
- Coefficient bank writes arrive from a host over a valid/ready stream.
- On each 600 kHz sample strobe it runs one fixed read/MAC burst over the selected coefficient bank.

Parameters:
NUM_TAPS, 10, coefficients per bank; legal range 2..16.
ADDR_W, 6, RAM address width: {bank[1:0], tap[3:0]}.
DATA_W, 16, coefficient width.

Ports:
iClk12M  in  1  12 MHz clock.
iRsn  in  1  asynchronous active-low reset.
iEnSample600k  in  1  one-cycle sample strobe.
iSampleIn  in  3  new filter input sample, captured on the strobe.
iRdBank  in  2  bank used by the burst, captured on the strobe.
iUpdateReq  in  1  level request for a coefficient update.
iUpdateBank  in  2  bank to write, captured when the request is accepted.
iCoeffValid  in  1  host coefficient word valid.
iCoeffData  in  16  host coefficient word.
oCoeffReady  out  1  block accepts a word this cycle.
oUpdateAck  out  1  one-cycle pulse when an update completes.
oBusy  out  1  high in any state except IDLE.
oOverrun  out  1  one-cycle pulse when a strobe is dropped.
oCoeffUpdateFlag, oCsnRam, oWrnRam  out  1 each  drive the same-named filter inputs.
oAddrRam  out  6  drives the filter RAM address.
oWtDtRam  out  16  drives the filter RAM write data.
oEnMul, oEnAddAcc  out  1 each  drive the filter MAC enables.
oFirIn  out  3  drives the filter input.

Behaviour:
- All outputs registered.
- Reset values: oCsnRam=1, oWrnRam=1; every other output 0; FSM in IDLE.
- Reset asserted mid-burst or mid-update aborts immediately to these values. No write is issued after reset asserts.

States: IDLE, SMP, RD, UPD_PRE, UPD_WR, UPD_POST.

Sample path (strobe seen in cycle S):
- IDLE + strobe -> SMP. In S+1: oFirIn=iSampleIn captured at S; bank latched.
- In S+2: oFirIn returns to 0; state RD.
- RD lasts NUM_TAPS cycles, called R0..R(N-1), R0=S+2. In Rk: oCsnRam=0, oWrnRam=1, oAddrRam={bank,k}.
- After R(N-1): oCsnRam=1, oAddrRam={bank,4'h0}; state IDLE.
- oEnMul is the read-active signal (CsnRam low with WrnRam high) delayed 1 cycle: high R1..RN.
- oEnAddAcc is that signal delayed 2 cycles: high R2..R(N+1).
- Implement both enables as a 2-stage shift of read-active, so they finish draining while the FSM is already back in IDLE.

Update path:
- IDLE + iUpdateReq with no strobe that cycle -> UPD_PRE: oCoeffUpdateFlag=1 for one cycle, no RAM access.
- UPD_WR:
  - oCoeffUpdateFlag=1, oCoeffReady=1.
  - On each cycle with iCoeffValid=1: oCsnRam=0, oWrnRam=0, oAddrRam={bank,k}, oWtDtRam=iCoeffData, then k++. Word index k counts 0..NUM_TAPS-1.
  - Cycles with iCoeffValid=0: oCsnRam=1, oWrnRam=1, address and data held.
  - The write of k=NUM_TAPS-1 ends the state: oCoeffReady drops the next cycle.
- UPD_POST: flag held high for 2 cycles with CSn/WRn=1 and address/data back to 0, then flag drops. oUpdateAck pulses in the first IDLE cycle.

Conflicts:
- Strobe and iUpdateReq in the same IDLE cycle: the sample wins. The request stays pending, because it is a level, and is taken at the first IDLE cycle with no strobe.
- Strobe in any non-IDLE state (SMP, RD, or any UPD_* state): strobe dropped, oOverrun pulses in the next cycle. Outputs are otherwise unaffected.
- An update never starts while oEnMul or oEnAddAcc is still draining. The FSM waits in IDLE until both are 0.
- Host is stalled only by oCoeffReady=0. There is no timeout.

Width rules:
- Tap counter is 4 bits and never wraps past NUM_TAPS-1.
- oAddrRam upper 2 bits = latched bank; the bank change applies at burst or update start only.

Decomposition:
- Package fir_ctrl_pkg: state enum; tap counter width constant; RAM bank/address field widths; the UPD_POST hold length (2) and SMP-to-RD gap (1).
- One natural sub-module, fir_mac_en_pipe: the 2-stage shift that produces oEnMul/oEnAddAcc from read-active. Everything else stays in the top module.

Test Plan:
- Reset, then hold Rsn low 3 cycles mid-burst -> outputs match the reset values within the same cycle; no further RAM read issued.
- Update bank 0 with words 0xA00..0xA09, valid every cycle -> flag high 1+10+2=13 cycles; writes at addr 0x00..0x09 in order; one oUpdateAck.
- Update bank 1 with valid dropped at k=3 and k=7 for 2 cycles each -> CSn high during the gaps; addresses 0x10..0x19; 10 writes total; flag high 17 cycles.
- Strobe with iSampleIn=3'b111, iRdBank=1 -> oFirIn=7 at S+1; reads at 0x10..0x19 in S+2..S+11; oEnMul high S+3..S+12; oEnAddAcc high S+4..S+13.
- Strobe plus iUpdateReq in the same cycle, and a second strobe during RD -> burst runs first, the update starts afterwards; the second strobe gives one oOverrun pulse and no extra burst.
- 20 strobes spaced 20 cycles apart (bank 0 x10, bank 1 x10) -> 20 bursts, zero overruns, oEnMul high exactly 10 cycles per burst.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR RAM control sequencer.
// No ports: state encoding, field widths, hold lengths, address helper.
package fir_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SMP,
        ST_RD,
        ST_UPD_PRE,
        ST_UPD_WR,
        ST_UPD_POST
    } state_t;

    localparam int TAP_W     = 4;
    localparam int BANK_W    = 2;
    localparam int FIR_W     = 3;
    localparam int HOLD_W    = 2;
    localparam int POST_HOLD = 2;
    localparam int SMP_GAP   = 1;

    function automatic logic [BANK_W+TAP_W-1:0] mk_addr(
        input logic [BANK_W-1:0] bank,
        input logic [TAP_W-1:0]  tap
    );
        return {bank, tap};
    endfunction

endpackage

// File: rtl/fir_mac_en_pipe.sv
// Two-stage shift turning RAM read-active into the filter MAC enables.
// Ports: iClk, iRsn, iRdAct in; oEnMul (1 cycle late), oEnAddAcc (2 late).
module fir_mac_en_pipe (
    input  logic iClk,
    input  logic iRsn,
    input  logic iRdAct,
    output logic oEnMul,
    output logic oEnAddAcc
);

    logic [1:0] r_shift;

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            r_shift <= 2'b00;
        end else begin
            r_shift <= {r_shift[0], iRdAct};
        end
    end

    assign oEnMul    = r_shift[0];
    assign oEnAddAcc = r_shift[1];

endmodule

// File: rtl/fir_ram_seq_ctrl.sv
// Control sequencer feeding ReConf_FirFilter: coefficient bank writes from
// a host stream, and one read/MAC burst per 600 kHz sample strobe.
// Ports: iClk12M/iRsn; strobe iEnSample600k+iSampleIn+iRdBank; update
// iUpdateReq+iUpdateBank; host stream iCoeffValid/iCoeffData/oCoeffReady;
// status oUpdateAck/oBusy/oOverrun; filter drives oCoeffUpdateFlag,
// oCsnRam, oWrnRam, oAddrRam, oWtDtRam, oEnMul, oEnAddAcc, oFirIn.
module fir_ram_seq_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int NUM_TAPS = 10,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16
) (
    input  logic              iClk12M,
    input  logic              iRsn,
    input  logic              iEnSample600k,
    input  logic [2:0]        iSampleIn,
    input  logic [1:0]        iRdBank,
    input  logic              iUpdateReq,
    input  logic [1:0]        iUpdateBank,
    input  logic              iCoeffValid,
    input  logic [DATA_W-1:0] iCoeffData,
    output logic              oCoeffReady,
    output logic              oUpdateAck,
    output logic              oBusy,
    output logic              oOverrun,
    output logic              oCoeffUpdateFlag,
    output logic              oCsnRam,
    output logic              oWrnRam,
    output logic [ADDR_W-1:0] oAddrRam,
    output logic [DATA_W-1:0] oWtDtRam,
    output logic              oEnMul,
    output logic              oEnAddAcc,
    output logic [2:0]        oFirIn
);

    localparam logic [TAP_W-1:0]  LAST_TAP  = TAP_W'(NUM_TAPS - 1);
    localparam logic [HOLD_W-1:0] SMP_LAST  = HOLD_W'(SMP_GAP - 1);
    localparam logic [HOLD_W-1:0] POST_LAST = HOLD_W'(POST_HOLD - 1);

    state_t              r_state, w_state;
    logic [TAP_W-1:0]    r_tap,   w_tap;
    logic [BANK_W-1:0]   r_bank,  w_bank;
    logic [HOLD_W-1:0]   r_hold,  w_hold;
    logic                r_flag,  w_flag;
    logic                r_csn,   w_csn;
    logic                r_wrn,   w_wrn;
    logic                r_ready, w_ready;
    logic                r_ack,   w_ack;
    logic                r_ovr,   w_ovr;
    logic                r_busy,  w_busy;
    logic [ADDR_W-1:0]   r_addr,  w_addr;
    logic [DATA_W-1:0]   r_wdata, w_wdata;
    logic [FIR_W-1:0]    r_fir,   w_fir;
    logic                w_rd_act;
    logic                w_en_mul;
    logic                w_en_acc;

    always_comb begin
        w_state = r_state;
        w_tap   = r_tap;
        w_bank  = r_bank;
        w_hold  = r_hold;
        w_flag  = 1'b0;
        w_csn   = 1'b1;
        w_wrn   = 1'b1;
        w_addr  = '0;
        w_wdata = '0;
        w_ready = 1'b0;
        w_ack   = 1'b0;
        w_fir   = '0;
        w_ovr   = iEnSample600k && (r_state != ST_IDLE);
        unique case (r_state)
            ST_IDLE: begin
                if (iEnSample600k) begin
                    w_state = ST_SMP;
                    w_bank  = iRdBank;
                    w_fir   = iSampleIn;
                    w_hold  = '0;
                end else if (iUpdateReq && !w_en_mul && !w_en_acc) begin
                    // MAC pipe must be empty before the RAM is rewritten
                    w_state = ST_UPD_PRE;
                    w_bank  = iUpdateBank;
                    w_flag  = 1'b1;
                end
            end
            ST_SMP: begin
                if (r_hold == SMP_LAST) begin
                    w_state = ST_RD;
                    w_tap   = '0;
                    w_csn   = 1'b0;
                    w_addr  = mk_addr(r_bank, '0);
                end else begin
                    w_hold = r_hold + 1'b1;
                end
            end
            ST_RD: begin
                if (r_tap == LAST_TAP) begin
                    w_state = ST_IDLE;
                    w_addr  = mk_addr(r_bank, '0);
                end else begin
                    w_tap  = r_tap + 1'b1;
                    w_csn  = 1'b0;
                    w_addr = mk_addr(r_bank, r_tap + 1'b1);
                end
            end
            ST_UPD_PRE: begin
                w_state = ST_UPD_WR;
                w_flag  = 1'b1;
                w_ready = 1'b1;
                w_tap   = '0;
            end
            ST_UPD_WR: begin
                w_flag = 1'b1;
                if (iCoeffValid) begin
                    w_csn   = 1'b0;
                    w_wrn   = 1'b0;
                    w_addr  = mk_addr(r_bank, r_tap);
                    w_wdata = iCoeffData;
                    if (r_tap == LAST_TAP) begin
                        w_state = ST_UPD_POST;
                        w_hold  = '0;
                    end else begin
                        w_tap   = r_tap + 1'b1;
                        w_ready = 1'b1;
                    end
                end else begin
                    w_ready = 1'b1;
                    w_addr  = r_addr;
                    w_wdata = r_wdata;
                end
            end
            ST_UPD_POST: begin
                // first post cycle carries the registered final write
                if (r_hold == POST_LAST) begin
                    w_state = ST_IDLE;
                    w_ack   = 1'b1;
                end else begin
                    w_flag = 1'b1;
                    w_hold = r_hold + 1'b1;
                end
            end
            default: w_state = ST_IDLE;
        endcase
        w_busy = (w_state != ST_IDLE);
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            r_state <= ST_IDLE;
            r_tap   <= '0;
            r_bank  <= '0;
            r_hold  <= '0;
            r_flag  <= 1'b0;
            r_csn   <= 1'b1;
            r_wrn   <= 1'b1;
            r_ready <= 1'b0;
            r_ack   <= 1'b0;
            r_ovr   <= 1'b0;
            r_busy  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_fir   <= '0;
        end else begin
            r_state <= w_state;
            r_tap   <= w_tap;
            r_bank  <= w_bank;
            r_hold  <= w_hold;
            r_flag  <= w_flag;
            r_csn   <= w_csn;
            r_wrn   <= w_wrn;
            r_ready <= w_ready;
            r_ack   <= w_ack;
            r_ovr   <= w_ovr;
            r_busy  <= w_busy;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_fir   <= w_fir;
        end
    end

    assign w_rd_act = ~r_csn & r_wrn;

    fir_mac_en_pipe u_en_pipe (
        .iClk      (iClk12M),
        .iRsn      (iRsn),
        .iRdAct    (w_rd_act),
        .oEnMul    (w_en_mul),
        .oEnAddAcc (w_en_acc)
    );

    assign oCoeffReady      = r_ready;
    assign oUpdateAck       = r_ack;
    assign oBusy            = r_busy;
    assign oOverrun         = r_ovr;
    assign oCoeffUpdateFlag = r_flag;
    assign oCsnRam          = r_csn;
    assign oWrnRam          = r_wrn;
    assign oAddrRam         = r_addr;
    assign oWtDtRam         = r_wdata;
    assign oEnMul           = w_en_mul;
    assign oEnAddAcc        = w_en_acc;
    assign oFirIn           = r_fir;

endmodule

// File: tb/tb_fir_ram_seq_ctrl.sv
// Self-checking bench for fir_ram_seq_ctrl: scoreboard of RAM accesses
// plus per-scenario timing and count checks.
module tb_fir_ram_seq_ctrl;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        iRsn;
    logic        iEnSample600k;
    logic [2:0]  iSampleIn;
    logic [1:0]  iRdBank;
    logic        iUpdateReq;
    logic [1:0]  iUpdateBank;
    logic        iCoeffValid;
    logic [15:0] iCoeffData;
    logic        oCoeffReady, oUpdateAck, oBusy, oOverrun;
    logic        oCoeffUpdateFlag, oCsnRam, oWrnRam;
    logic [5:0]  oAddrRam;
    logic [15:0] oWtDtRam;
    logic        oEnMul, oEnAddAcc;
    logic [2:0]  oFirIn;

    fir_ram_seq_ctrl #(.NUM_TAPS(N), .ADDR_W(6), .DATA_W(16)) dut (
        .iClk12M          (clk),
        .iRsn             (iRsn),
        .iEnSample600k    (iEnSample600k),
        .iSampleIn        (iSampleIn),
        .iRdBank          (iRdBank),
        .iUpdateReq       (iUpdateReq),
        .iUpdateBank      (iUpdateBank),
        .iCoeffValid      (iCoeffValid),
        .iCoeffData       (iCoeffData),
        .oCoeffReady      (oCoeffReady),
        .oUpdateAck       (oUpdateAck),
        .oBusy            (oBusy),
        .oOverrun         (oOverrun),
        .oCoeffUpdateFlag (oCoeffUpdateFlag),
        .oCsnRam          (oCsnRam),
        .oWrnRam          (oWrnRam),
        .oAddrRam         (oAddrRam),
        .oWtDtRam         (oWtDtRam),
        .oEnMul           (oEnMul),
        .oEnAddAcc        (oEnAddAcc),
        .oFirIn           (oFirIn)
    );

    always #5 clk = ~clk;

    logic [5:0]  exp_rd[$];
    logic [21:0] exp_wr[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int c_rd = 0, c_wr = 0, c_mul = 0, c_acc = 0;
    int c_flag = 0, c_ack = 0, c_ovr = 0;
    int last_rd_cyc = 0;

    int hk;
    logic [15:0] hbase;
    int gap_a, gap_b, rem_a, rem_b;

    localparam logic [33:0] RST_VEC = {2'b11, 32'h0};

    // Advance one clock; log strobes and score any RAM access seen.
    task automatic step();
        logic [5:0]  ea;
        logic [21:0] ew;
        @(posedge clk);
        #1;
        cyc++;
        if (oEnMul) c_mul++;
        if (oEnAddAcc) c_acc++;
        if (oCoeffUpdateFlag) c_flag++;
        if (oUpdateAck) c_ack++;
        if (oOverrun) c_ovr++;
        if (!oCsnRam && oWrnRam) begin
            c_rd++;
            last_rd_cyc = cyc;
            n_cmp++;
            if (exp_rd.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: addr=%h, none expected", oAddrRam);
            end else begin
                ea = exp_rd.pop_front();
                if (oAddrRam !== ea) begin
                    n_err++;
                    $display("FAIL rd_addr: got %h, want %h", oAddrRam, ea);
                end
            end
        end
        if (!oCsnRam && !oWrnRam) begin
            c_wr++;
            n_cmp++;
            if (exp_wr.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected: addr=%h data=%h", oAddrRam, oWtDtRam);
            end else begin
                ew = exp_wr.pop_front();
                if ({oAddrRam, oWtDtRam} !== ew) begin
                    n_err++;
                    $display("FAIL wr_addr_data: got %h/%h, want %h/%h",
                             oAddrRam, oWtDtRam, ew[21:16], ew[15:0]);
                end
            end
        end
    endtask

    task automatic strobe(input logic [2:0] s, input logic [1:0] b,
                          input bit expect_burst);
        iEnSample600k = 1'b1;
        iSampleIn     = s;
        iRdBank       = b;
        if (expect_burst)
            for (int k = 0; k < N; k++) exp_rd.push_back({b, 4'(k)});
        step();
        iEnSample600k = 1'b0;
        iSampleIn     = 3'd0;
    endtask

    task automatic start_update(input logic [1:0] b, input logic [15:0] base,
                                input int ga, input int gb);
        iUpdateReq  = 1'b1;
        iUpdateBank = b;
        hk    = 0;
        hbase = base;
        gap_a = ga;
        gap_b = gb;
        rem_a = 2;
        rem_b = 2;
        for (int k = 0; k < N; k++)
            exp_wr.push_back({b, 4'(k), base + 16'(k)});
    endtask

    task automatic host_cycle(output bit stalled);
        bit acc;
        stalled     = 1'b0;
        iCoeffValid = 1'b0;
        if (oCoeffReady && hk < N) begin
            if (hk == gap_a && rem_a > 0) begin
                rem_a--;
                stalled = 1'b1;
            end else if (hk == gap_b && rem_b > 0) begin
                rem_b--;
                stalled = 1'b1;
            end else begin
                iCoeffValid = 1'b1;
                iCoeffData  = hbase + 16'(hk);
            end
        end
        acc = iCoeffValid && oCoeffReady;
        step();
        if (acc) hk++;
        iCoeffValid = 1'b0;
        if (oCoeffUpdateFlag) iUpdateReq = 1'b0;
    endtask

    task automatic test_reset();
        logic [33:0] v;
        iRsn = 1'b0;
        repeat (2) step();
        v = {oCsnRam, oWrnRam, oCoeffUpdateFlag, oCoeffReady, oUpdateAck,
             oBusy, oOverrun, oEnMul, oEnAddAcc, oAddrRam, oWtDtRam, oFirIn};
        n_cmp++;
        if (v !== RST_VEC) begin
            n_err++;
            $display("FAIL reset_vec: got %h, want %h", v, RST_VEC);
        end
        iRsn = 1'b1;
        repeat (2) step();
        n_cmp++;
        if (oBusy !== 1'b0 || oCsnRam !== 1'b1) begin
            n_err++;
            $display("FAIL reset_idle: busy=%b csn=%b, want 0/1", oBusy, oCsnRam);
        end
    endtask

    task automatic run_update(input logic [1:0] b, input logic [15:0] base,
                              input int ga, input int gb, input int want_flag,
                              input string tag);
        int f0, a0, w0, r0;
        bit st, done;
        f0 = c_flag; a0 = c_ack; w0 = c_wr; r0 = c_rd;
        done = 1'b0;
        start_update(b, base, ga, gb);
        for (int i = 0; i < 100 && !done; i++) begin
            host_cycle(st);
            if (st) begin
                n_cmp++;
                if (oCsnRam !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s_gap_csn: got %b, want 1", tag, oCsnRam);
                end
            end
            if (oUpdateAck) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s_timeout: no ack, want ack within 100 cycles", tag);
        end
        repeat (5) step();
        n_cmp++;
        if (c_flag - f0 != want_flag) begin
            n_err++;
            $display("FAIL %s_flag_cycles: got %0d, want %0d", tag, c_flag - f0, want_flag);
        end
        n_cmp++;
        if (c_wr - w0 != N || c_rd != r0) begin
            n_err++;
            $display("FAIL %s_access_count: wr=%0d rd=%0d, want %0d/0",
                     tag, c_wr - w0, c_rd - r0, N);
        end
        n_cmp++;
        if (c_ack - a0 != 1 || exp_wr.size() != 0) begin
            n_err++;
            $display("FAIL %s_ack: acks=%0d left=%0d, want 1/0",
                     tag, c_ack - a0, exp_wr.size());
        end
    endtask

    task automatic test_burst();
        int rf, rl, mf, ml, af, al;
        rf = -1; rl = -1; mf = -1; ml = -1; af = -1; al = -1;
        strobe(3'b111, 2'd1, 1'b1);
        n_cmp++;
        if (oFirIn !== 3'd7 || oBusy !== 1'b1) begin
            n_err++;
            $display("FAIL burst_fir_in: fir=%0d busy=%b, want 7/1", oFirIn, oBusy);
        end
        for (int t = 2; t <= 16; t++) begin
            step();
            if (t == 2) begin
                n_cmp++;
                if (oFirIn !== 3'd0 || oAddrRam !== 6'h10) begin
                    n_err++;
                    $display("FAIL burst_r0: fir=%0d addr=%h, want 0/10", oFirIn, oAddrRam);
                end
            end
            if (!oCsnRam && oWrnRam) begin if (rf < 0) rf = t; rl = t; end
            if (oEnMul) begin if (mf < 0) mf = t; ml = t; end
            if (oEnAddAcc) begin if (af < 0) af = t; al = t; end
        end
        n_cmp++;
        if (rf != 2 || rl != 11) begin
            n_err++;
            $display("FAIL burst_rd_window: got S+%0d..S+%0d, want S+2..S+11", rf, rl);
        end
        n_cmp++;
        if (mf != 3 || ml != 12) begin
            n_err++;
            $display("FAIL burst_enmul_window: got S+%0d..S+%0d, want S+3..S+12", mf, ml);
        end
        n_cmp++;
        if (af != 4 || al != 13) begin
            n_err++;
            $display("FAIL burst_enacc_window: got S+%0d..S+%0d, want S+4..S+13", af, al);
        end
    endtask

    task automatic test_conflict();
        int o0, r0, w0, a0, ff;
        bit st, done;
        o0 = c_ovr; r0 = c_rd; w0 = c_wr; a0 = c_ack;
        ff = -1;
        done = 1'b0;
        start_update(2'd2, 16'h0C00, -1, -1);
        strobe(3'd3, 2'd0, 1'b1);
        for (int i = 0; i < 120 && !done; i++) begin
            if (i == 4) strobe(3'd5, 2'd1, 1'b0);
            else host_cycle(st);
            if (oCoeffUpdateFlag && ff < 0) ff = cyc;
            if (oUpdateAck) done = 1'b1;
        end
        repeat (5) step();
        n_cmp++;
        if (!done || ff - last_rd_cyc != 4) begin
            n_err++;
            $display("FAIL conflict_order: done=%b flag-lastrd=%0d, want 1/4",
                     done, ff - last_rd_cyc);
        end
        n_cmp++;
        if (c_ovr - o0 != 1) begin
            n_err++;
            $display("FAIL conflict_overrun: got %0d, want 1", c_ovr - o0);
        end
        n_cmp++;
        if (c_rd - r0 != N || c_wr - w0 != N || c_ack - a0 != 1) begin
            n_err++;
            $display("FAIL conflict_counts: rd=%0d wr=%0d ack=%0d, want %0d/%0d/1",
                     c_rd - r0, c_wr - w0, c_ack - a0, N, N);
        end
    endtask

    task automatic test_back_to_back();
        int o0, r0, m0;
        o0 = c_ovr; r0 = c_rd;
        for (int b = 0; b < 20; b++) begin
            m0 = c_mul;
            strobe(3'(b), (b < 10) ? 2'd0 : 2'd1, 1'b1);
            repeat (19) step();
            n_cmp++;
            if (c_mul - m0 != N) begin
                n_err++;
                $display("FAIL b2b_enmul_%0d: got %0d, want %0d", b, c_mul - m0, N);
            end
        end
        n_cmp++;
        if (c_ovr != o0 || c_rd - r0 != 20 * N || exp_rd.size() != 0) begin
            n_err++;
            $display("FAIL b2b_totals: ovr=%0d rd=%0d left=%0d, want 0/%0d/0",
                     c_ovr - o0, c_rd - r0, exp_rd.size(), 20 * N);
        end
    endtask

    task automatic test_reset_midburst();
        logic [33:0] v;
        int r0, m0;
        strobe(3'd2, 2'd0, 1'b1);
        repeat (4) step();
        iRsn = 1'b0;
        #1;
        v = {oCsnRam, oWrnRam, oCoeffUpdateFlag, oCoeffReady, oUpdateAck,
             oBusy, oOverrun, oEnMul, oEnAddAcc, oAddrRam, oWtDtRam, oFirIn};
        n_cmp++;
        if (v !== RST_VEC) begin
            n_err++;
            $display("FAIL midburst_reset_vec: got %h, want %h", v, RST_VEC);
        end
        r0 = c_rd; m0 = c_mul;
        repeat (3) step();
        iRsn = 1'b1;
        exp_rd.delete();
        repeat (20) step();
        n_cmp++;
        if (c_rd != r0 || c_mul != m0) begin
            n_err++;
            $display("FAIL midburst_no_resume: rd=%0d mul=%0d, want 0/0",
                     c_rd - r0, c_mul - m0);
        end
    endtask

    initial begin
        iRsn = 1'b0;
        iEnSample600k = 1'b0;
        iSampleIn = 3'd0;
        iRdBank = 2'd0;
        iUpdateReq = 1'b0;
        iUpdateBank = 2'd0;
        iCoeffValid = 1'b0;
        iCoeffData = 16'h0;
        test_reset();
        run_update(2'd0, 16'h0A00, -1, -1, 13, "upd_b0");
        run_update(2'd1, 16'h0B00, 3, 7, 17, "upd_gaps");
        test_burst();
        test_conflict();
        test_back_to_back();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
